// File: rtl/ternary_acc_pkg.sv
// ---------------------------------------------------------------------------
// ternary_acc_pkg
// Shared widths, limits, types and the saturating accumulate helper for the
// ternary dot-product accumulator slice.
//   IN_W    : width of the signed partial dot product from the ternary unit
//   ACC_W   : width of the signed saturating accumulator
//   OUT_W   : width of the signed requantised activation
//   SHIFT_W : width of the runtime right-shift control
// ---------------------------------------------------------------------------
package ternary_acc_pkg;

    localparam int IN_W    = 16;
    localparam int ACC_W   = 24;
    localparam int OUT_W   = 8;
    localparam int SHIFT_W = 4;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [ACC_W:0]   accx_t;
    typedef logic signed [OUT_W-1:0] out_t;
    typedef logic signed [IN_W-1:0]  in_t;

    localparam acc_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam acc_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam out_t OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam out_t OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    typedef struct packed {
        acc_t sum;
        logic clamped;
    } sat_sum_t;

    // Add one partial sum to the accumulator one bit wider than the
    // accumulator; if the two top bits disagree the true sum left the
    // accumulator range and the top bit tells which rail to clamp to.
    function automatic sat_sum_t satAccAdd(input acc_t acc, input in_t data);
        accx_t    wide;
        sat_sum_t res;
        wide = accx_t'(acc) + accx_t'(data);
        res.clamped = wide[ACC_W] ^ wide[ACC_W-1];
        if (!res.clamped) begin
            res.sum = wide[ACC_W-1:0];
        end else if (wide[ACC_W]) begin
            res.sum = ACC_MIN;
        end else begin
            res.sum = ACC_MAX;
        end
        return res;
    endfunction

endpackage

// File: rtl/ternary_requant.sv
// ---------------------------------------------------------------------------
// ternary_requant
// Combinational requantiser: rounding arithmetic right shift, optional ReLU,
// then saturation to the signed output width.
//   sum_i   : saturated accumulator value for the finished vector
//   shift_i : right-shift amount (0 leaves the sum unshifted)
//   relu_i  : 1 = clamp negative rounded results to zero
//   data_o  : requantised activation
//   clamp_o : output saturation occurred (ReLU zeroing does not count)
// ---------------------------------------------------------------------------
module ternary_requant
    import ternary_acc_pkg::*;
(
    input  acc_t               sum_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic               relu_i,
    output out_t               data_o,
    output logic               clamp_o
);

    accx_t              bias;
    accx_t              rounded;
    logic [SHIFT_W-1:0] shiftMinusOne;

    // Rounding is done one bit wider than the accumulator so that adding
    // half an LSB to a value at the positive rail cannot wrap negative.
    // ReLU is applied to the rounded value, then the result is clamped
    // to the output range and the clamp is reported.
    always_comb begin
        bias          = '0;
        shiftMinusOne = shift_i - {{(SHIFT_W-1){1'b0}}, 1'b1};
        if (shift_i != '0) begin
            bias = accx_t'(1) <<< shiftMinusOne;
        end
        rounded = (accx_t'(sum_i) + bias) >>> shift_i;

        if (relu_i && rounded[ACC_W]) begin
            rounded = '0;
        end

        data_o  = rounded[OUT_W-1:0];
        clamp_o = 1'b0;
        if (rounded > accx_t'(OUT_MAX)) begin
            data_o  = OUT_MAX;
            clamp_o = 1'b1;
        end else if (rounded < accx_t'(OUT_MIN)) begin
            data_o  = OUT_MIN;
            clamp_o = 1'b1;
        end
    end

endmodule

// File: rtl/ternary_dot_accumulator.sv
// ---------------------------------------------------------------------------
// ternary_dot_accumulator
// Accumulates the 16-bit partial dot products of one neuron's input vector,
// requantises the sum to int8 and offers it on a valid/ready output.
//   clk, rst             : clock and synchronous active-high reset
//   in_valid/in_ready    : partial-sum handshake
//   in_data, in_last     : signed partial sum, last chunk of the vector
//   cfg_shift, cfg_relu  : requantisation controls, taken with the last beat
//   out_valid/out_ready  : activation handshake
//   out_data, out_sat    : activation and "some saturation happened" flag
// ---------------------------------------------------------------------------
module ternary_dot_accumulator
    import ternary_acc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_data,
    input  logic               in_last,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic               cfg_relu,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_sat
);

    state_e   state_q;
    state_e   state_d;
    acc_t     acc_q;
    acc_t     acc_d;
    logic     ovf_q;
    logic     ovf_d;
    out_t     outData_q;
    out_t     outData_d;
    logic     outSat_q;
    logic     outSat_d;

    sat_sum_t addRes;
    out_t     reqData;
    logic     reqClamp;
    logic     beatAccept;
    logic     lastAccept;

    // The incoming beat is always added speculatively; whether the result
    // is kept depends on the handshake below.
    always_comb begin
        addRes = satAccAdd(acc_q, in_t'(in_data));
    end

    ternary_requant u_requant (
        .sum_i   (addRes.sum),
        .shift_i (cfg_shift),
        .relu_i  (cfg_relu),
        .data_o  (reqData),
        .clamp_o (reqClamp)
    );

    // State register: HOLD means the output register carries an activation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a finished vector always lands in HOLD, even while the
    // previous one drains, which gives one vector per cycle back-to-back.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM: if (lastAccept) state_d = HOLD;
            HOLD:  if (out_ready && !lastAccept) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // Handshake outputs. in_ready depends only on the output register and
    // out_ready, so there is no path from in_valid back to in_ready.
    always_comb begin
        out_valid  = (state_q == HOLD);
        in_ready   = !out_valid || out_ready;
        beatAccept = in_valid && in_ready;
        lastAccept = beatAccept && in_last;
    end

    // Datapath next state: the last beat loads the output register and
    // clears the accumulator in the same edge so the next vector starts
    // clean; a stalled or idle cycle leaves everything untouched.
    always_comb begin
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        outData_d = outData_q;
        outSat_d  = outSat_q;
        if (lastAccept) begin
            acc_d     = '0;
            ovf_d     = 1'b0;
            outData_d = reqData;
            outSat_d  = ovf_q || addRes.clamped || reqClamp;
        end else if (beatAccept) begin
            acc_d = addRes.sum;
            ovf_d = ovf_q || addRes.clamped;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            outData_q <= '0;
            outSat_q  <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            outData_q <= outData_d;
            outSat_q  <= outSat_d;
        end
    end

    assign out_data = outData_q;
    assign out_sat  = outSat_q;

endmodule

// File: tb/tb_ternary_dot_accumulator.sv
// ---------------------------------------------------------------------------
// tb_ternary_dot_accumulator
// Directed bench for the ternary dot accumulator with hand-computed results.
// ---------------------------------------------------------------------------
module tb_ternary_dot_accumulator;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic signed [15:0] in_data;
    logic              in_last;
    logic [3:0]        cfg_shift;
    logic              cfg_relu;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_data;
    logic              out_sat;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    ternary_dot_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .cfg_shift (cfg_shift),
        .cfg_relu  (cfg_relu),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends even if the sequence gets stuck.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string tag, input logic signed [31:0] obs,
                            input logic signed [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one beat for exactly one rising edge, then sample #1 later.
    task automatic applyStimulus(input logic v, input logic signed [15:0] d,
                                 input logic l, input logic [3:0] sh,
                                 input logic rl);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        cfg_shift = sh;
        cfg_relu  = rl;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input int expValid,
                               input int expData, input int expSat);
        checkVal({tag, "/valid"}, 32'(out_valid), expValid);
        if (expValid != 0) begin
            checkVal({tag, "/data"}, 32'(out_data), expData);
            checkVal({tag, "/sat"}, 32'(out_sat), expSat);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        cfg_shift = '0;
        cfg_relu  = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkVal("reset/valid", 32'(out_valid), 0);
        checkVal("reset/data", 32'(out_data), 0);
        checkVal("reset/sat", 32'(out_sat), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkVal("reset/in_ready", 32'(in_ready), 1);

        // Single-beat vector, then the output drains
        applyStimulus(1, 100, 1, 0, 0);
        checkOutput("single", 1, 100, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("single_drain", 0, 0, 0);

        // 1000 + 2000 - 500 = 2500, shift 4 -> 156 -> clamps to 127
        applyStimulus(1, 1000, 0, 0, 0);
        applyStimulus(1, 2000, 0, 0, 0);
        applyStimulus(1, -500, 1, 4, 0);
        checkOutput("three_sh4", 1, 127, 1);
        applyStimulus(0, 0, 0, 0, 0);

        // Same vector with shift 5 -> 78
        applyStimulus(1, 1000, 0, 0, 0);
        applyStimulus(1, 2000, 0, 0, 0);
        applyStimulus(1, -500, 1, 5, 0);
        checkOutput("three_sh5", 1, 78, 0);

        // Negative single beats, issued back-to-back while draining
        applyStimulus(1, -300, 1, 0, 1);
        checkOutput("neg_relu", 1, 0, 0);
        applyStimulus(1, -300, 1, 0, 0);
        checkOutput("neg_sat", 1, -128, 1);
        applyStimulus(1, -300, 1, 2, 0);
        checkOutput("neg_sh2", 1, -75, 0);

        // Rounding with shift 1: (3+1)>>>1 = 2, (-3+1)>>>1 = -1
        applyStimulus(1, 3, 1, 1, 0);
        checkOutput("round_pos", 1, 2, 0);
        applyStimulus(1, -3, 1, 1, 0);
        checkOutput("round_neg", 1, -1, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("round_drain", 0, 0, 0);

        // Backpressure: output full, consumer stalled for five cycles
        out_ready = 1'b0;
        applyStimulus(1, 40, 1, 0, 0);
        checkOutput("bp_load", 1, 40, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 16'sd10;
            in_last  = 1'b0;
            #1;
            checkVal("bp/in_ready", 32'(in_ready), 0);
            @(posedge clk);
            #1;
            checkOutput("bp_hold", 1, 40, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'sd7;
        in_last   = 1'b1;
        cfg_shift = '0;
        cfg_relu  = 1'b0;
        #1;
        checkVal("bp_release/in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        checkOutput("bp_b2b", 1, 7, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("bp_drain", 0, 0, 0);

        // Accumulator saturation: 257 * 32767 exceeds 2^23-1
        for (int i = 0; i < 257; i++) begin
            applyStimulus(1, 32767, 0, 0, 0);
        end
        applyStimulus(1, 0, 1, 15, 0);
        checkOutput("acc_sat", 1, 127, 1);
        applyStimulus(1, 5, 1, 0, 0);
        checkOutput("after_sat", 1, 5, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Reset mid-vector discards the partial sum
        applyStimulus(1, 700, 0, 0, 0);
        applyStimulus(1, 800, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkVal("midrst/valid", 32'(out_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("midrst_idle", 0, 0, 0);
        applyStimulus(1, 5, 1, 0, 0);
        checkOutput("midrst_next", 1, 5, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
